// File: rtl/wb_buffer_pkg.sv
// Shared definitions for the write buffer: request type codes, AXI constants,
// the drain FSM encoding and the buffered entry layout.
package wb_buffer_pkg;

    localparam logic [2:0] WR_BYTE = 3'd0;
    localparam logic [2:0] WR_HALF = 3'd1;
    localparam logic [2:0] WR_WORD = 3'd2;
    localparam logic [2:0] WR_LINE = 3'd4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_BYTE  = 3'd0;
    localparam logic [2:0] AXI_SIZE_HALF  = 3'd1;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [3:0] AXI_WRITE_ID   = 4'd1;
    localparam logic [7:0] AXI_LEN_LINE   = 8'd3;

    typedef enum logic [1:0] {
        StIdle,
        StAw,
        StW,
        StB
    } drain_state_e;

    typedef struct packed {
        logic [2:0]   wtype;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);
    // Bit offset of addr[4] inside a flattened entry (data and wstrb sit below addr).
    localparam int unsigned ENTRY_LINE_LSB = 128 + 4 + 4;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO exposing its head, every slot and a per-slot valid
// mask so the parent can search all pending entries.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH-1:0]       head,
    output logic [DEPTH*WIDTH-1:0] entries,
    output logic [DEPTH-1:0]       valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        entries = '0;
        valid   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr_q;
            entries[i*WIDTH +: WIDTH] = mem_q[i];
            valid[i] = (CNT_W'(off) < count_q);
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Data-cache write buffer: queues byte/half/word/line writes and drains them
// one at a time as AXI write bursts, flagging read hazards against pending lines.
module wb_buffer
    import wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic         buf_empty,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    drain_state_e           state_q, state_d;
    logic [1:0]             beat_q, beat_d;
    logic                   pop, fifo_full, fifo_empty, head_line;
    wb_entry_t              push_entry, head;
    logic [DEPTH*ENTRY_W-1:0] entries;
    logic [DEPTH-1:0]       valid;
    logic                   unused_bits;

    assign push_entry = '{wtype: wr_type, addr: wr_addr, wstrb: wr_wstrb, data: wr_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .push    (wr_req),
        .din     (push_entry),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head),
        .entries (entries),
        .valid   (valid)
    );

    assign wr_rdy    = !fifo_full;
    assign buf_empty = fifo_empty && (state_q == StIdle);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: if (!fifo_empty) state_d = StAw;
            StAw: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_d = StW;
                    beat_d  = '0;
                end
            end
            StW: begin
                wvalid = 1'b1;
                if (wready) begin
                    beat_d = beat_q + 2'd1;
                    if (wlast) state_d = StB;
                end
            end
            StB: begin
                bready = 1'b1;
                // Entry stays in the FIFO until here so chk_hit covers the in-flight write.
                if (bvalid) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Payload comes straight from the head entry, which cannot move until the pop.
    assign head_line = (head.wtype == WR_LINE);
    assign awid      = AXI_WRITE_ID;
    assign wid       = AXI_WRITE_ID;
    assign awburst   = AXI_BURST_INCR;
    assign awlock    = '0;
    assign awcache   = '0;
    assign awprot    = '0;
    assign awaddr    = head_line ? {head.addr[31:4], 4'h0} : head.addr;
    assign awlen     = head_line ? AXI_LEN_LINE : 8'd0;
    assign awsize    = head_line ? AXI_SIZE_WORD : {1'b0, head.wtype[1:0]};
    assign wstrb     = head_line ? 4'hF : head.wstrb;
    assign wdata     = head_line ? head.data[{beat_q, 5'd0} +: 32] : head.data[31:0];
    assign wlast     = (awlen == {6'd0, beat_q});

    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i] && entries[i*ENTRY_W + ENTRY_LINE_LSB +: 28] == chk_addr[31:4]) begin
                chk_hit = 1'b1;
            end
        end
    end

    assign unused_bits = ^{bid, bresp, chk_addr[3:0], entries};

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: table of single writes drained over AXI, plus
// full-buffer back-pressure, hazard and mid-burst reset sequences.
module tb_wb_buffer;

    logic         aclk = 1'b0;
    logic         areset;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  chk_addr;
    logic         chk_hit, buf_empty;
    logic [3:0]   awid, awcache, wid, wstrb, bid;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock, bresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_bad = 0;

    wb_buffer #(.DEPTH(2)) dut (
        .aclk(aclk), .areset(areset), .wr_req(wr_req), .wr_type(wr_type),
        .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .buf_empty(buf_empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [2:0]       wtype;
        logic [31:0]      addr;
        logic [3:0]       wstrb;
        logic [127:0]     data;
        logic [31:0]      exp_awaddr;
        logic [7:0]       exp_awlen;
        logic [2:0]       exp_awsize;
        logic [3:0]       exp_wstrb;
        logic [3:0][31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                                input logic [127:0] d, input logic [31:0] ea, input logic [7:0] el,
                                input logic [2:0] es, input logic [3:0] ew,
                                input logic [127:0] ed);
        vec_t v;
        v.wtype = t; v.addr = a; v.wstrb = s; v.data = d;
        v.exp_awaddr = ea; v.exp_awlen = el; v.exp_awsize = es; v.exp_wstrb = ew;
        v.exp_wdata = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic push(input vec_t v);
        wr_type = v.wtype; wr_addr = v.addr; wr_wstrb = v.wstrb; wr_data = v.data;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
    endtask

    // Drive one buffered entry through AW, W and B, checking every beat.
    task automatic drain(input vec_t v, input bit stall);
        int cyc;
        int beat;
        bit acc;
        cyc = 0;
        while (!awvalid && cyc < 8) begin
            step();
            cyc++;
        end
        chk("awvalid", 32'(awvalid), 32'd1);
        chk("awaddr", awaddr, v.exp_awaddr);
        chk("awlen", 32'(awlen), 32'(v.exp_awlen));
        chk("awsize", 32'(awsize), 32'(v.exp_awsize));
        chk("awburst", 32'(awburst), 32'd1);
        chk("awid", 32'(awid), 32'd1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(v.exp_awlen) && cyc < 64) begin
            chk("wvalid", 32'(wvalid), 32'd1);
            chk("wdata", wdata, v.exp_wdata[beat]);
            chk("wstrb", 32'(wstrb), 32'(v.exp_wstrb));
            chk("wlast", 32'(wlast), 32'(beat == int'(v.exp_awlen)));
            chk("wid", 32'(wid), 32'd1);
            acc = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            wready = acc;
            step();
            wready = 1'b0;
            if (acc) beat++;
            cyc++;
        end
        chk("beat_count", 32'(beat), 32'(v.exp_awlen) + 32'd1);
        chk("bready", 32'(bready), 32'd1);
        chk("wvalid_in_b", 32'(wvalid), 32'd0);
        chk_addr = v.addr;
        #1;
        chk("chk_hit_pending", 32'(chk_hit), 32'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("chk_hit_after_b", 32'(chk_hit), 32'd0);
        chk("bready_after_b", 32'(bready), 32'd0);
    endtask

    vec_t vecs[5];
    vec_t va, vb, vc, vr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(3'd4, 32'h1C00_0010, 4'h0,
                     128'h00000044_00000033_00000022_00000011,
                     32'h1C00_0010, 8'd3, 3'd2, 4'hF,
                     128'h00000044_00000033_00000022_00000011);
        vecs[1] = mk(3'd0, 32'h1C00_0003, 4'b1000,
                     128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AB000000,
                     32'h1C00_0003, 8'd0, 3'd0, 4'b1000, 128'hAB000000);
        vecs[2] = mk(3'd1, 32'h2000_0006, 4'b1100, 128'hBEEF0000,
                     32'h2000_0006, 8'd0, 3'd1, 4'b1100, 128'hBEEF0000);
        vecs[3] = mk(3'd2, 32'h3000_0008, 4'hF, 128'hDEADBEEF,
                     32'h3000_0008, 8'd0, 3'd2, 4'hF, 128'hDEADBEEF);
        vecs[4] = mk(3'd4, 32'h4000_0027, 4'b0001,
                     128'h0D0E0F10_090A0B0C_05060708_01020304,
                     32'h4000_0020, 8'd3, 3'd2, 4'hF,
                     128'h0D0E0F10_090A0B0C_05060708_01020304);

        areset = 1'b1; wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0;
        wr_data = '0; chk_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        bid = 4'd3; bresp = 2'd2;
        #12;
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_buf_empty", 32'(buf_empty), 32'd1);
        chk("rst_chk_hit", 32'(chk_hit), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_lock_cache_prot", {23'd0, awlock, awcache, awprot}, 32'd0);
        @(posedge aclk);
        #2;
        areset = 1'b0;
        step();

        // Single writes, one at a time; the last one sees random W back-pressure.
        for (int i = 0; i < 5; i++) begin
            chk("tbl_wr_rdy", 32'(wr_rdy), 32'd1);
            push(vecs[i]);
            chk("tbl_awvalid_idle", 32'(awvalid), 32'd0);
            chk("tbl_not_empty", 32'(buf_empty), 32'd0);
            step();
            chk("tbl_awvalid_next", 32'(awvalid), 32'd1);
            drain(vecs[i], i == 4);
            chk("tbl_buf_empty", 32'(buf_empty), 32'd1);
        end

        // Fill with AW stalled, then hold a third request until the first B.
        va = mk(3'd4, 32'h1C00_0040, 4'h0, 128'h000000D4_000000C3_000000B2_000000A1,
                32'h1C00_0040, 8'd3, 3'd2, 4'hF, 128'h000000D4_000000C3_000000B2_000000A1);
        vb = mk(3'd2, 32'h2000_0100, 4'hF, 128'h12345678,
                32'h2000_0100, 8'd0, 3'd2, 4'hF, 128'h12345678);
        vc = mk(3'd1, 32'h3000_0202, 4'b0011, 128'h0000BEEF,
                32'h3000_0202, 8'd0, 3'd1, 4'b0011, 128'h0000BEEF);
        push(va);
        chk("full1_wr_rdy", 32'(wr_rdy), 32'd1);
        push(vb);
        chk("full2_wr_rdy", 32'(wr_rdy), 32'd0);
        wr_type = vc.wtype; wr_addr = vc.addr; wr_wstrb = vc.wstrb; wr_data = vc.data;
        wr_req = 1'b1;
        step();
        step();
        chk("full_hold_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("full_aw_stall", 32'(awvalid), 32'd1);
        chk_addr = 32'h1C00_004C;
        #1;
        chk("hit_same_line", 32'(chk_hit), 32'd1);
        chk_addr = 32'h1C00_0050;
        #1;
        chk("hit_next_line", 32'(chk_hit), 32'd0);
        drain(va, 1'b0);
        chk("rdy_after_b", 32'(wr_rdy), 32'd1);
        step();
        wr_req = 1'b0;
        drain(vb, 1'b0);
        drain(vc, 1'b0);
        chk("seq_buf_empty", 32'(buf_empty), 32'd1);

        // Reset in the middle of a line burst.
        vr = mk(3'd4, 32'h5000_0000, 4'h0, 128'hA4_000000A3_000000A2_000000A1,
                32'h5000_0000, 8'd3, 3'd2, 4'hF, 128'hA4_000000A3_000000A2_000000A1);
        push(vr);
        step();
        chk("rst_seq_aw", 32'(awvalid), 32'd1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        wready = 1'b1;
        step();
        step();
        wready = 1'b0;
        chk("rst_seq_wvalid", 32'(wvalid), 32'd1);
        chk("rst_seq_wdata", wdata, 32'hA3);
        chk_addr = 32'h5000_0004;
        #1;
        areset = 1'b1;
        #1;
        chk("mid_rst_awvalid", 32'(awvalid), 32'd0);
        chk("mid_rst_wvalid", 32'(wvalid), 32'd0);
        chk("mid_rst_bready", 32'(bready), 32'd0);
        chk("mid_rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("mid_rst_buf_empty", 32'(buf_empty), 32'd1);
        chk("mid_rst_chk_hit", 32'(chk_hit), 32'd0);
        step();
        step();
        areset = 1'b0;
        begin
            int seen;
            seen = 0;
            wready = 1'b1;
            awready = 1'b1;
            repeat (6) begin
                step();
                if (wvalid || awvalid) seen++;
            end
            wready = 1'b0;
            awready = 1'b0;
            chk("no_traffic_after_reset", 32'(seen), 32'd0);
        end
        chk("post_rst_buf_empty", 32'(buf_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
